// File: rtl/axi_stream_arb_mux.sv
// rtl/axi_stream_arb_mux.sv - N-channel packet-aware round-robin stream mux with registered output.
// Optional AXIS_MUX_EXT_SEL_EN adds an external channel select used while idle.
module axi_stream_arb_mux #(
  parameter  int N_CH    = 4,
  parameter  int DATA_WD = 8,
  localparam int CH_WD   = $clog2(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef AXIS_MUX_EXT_SEL_EN
  input  logic [CH_WD-1:0]        ext_sel,
  input  logic                    ext_sel_en,
`endif
  input  logic [N_CH-1:0]         s_valid,
  input  logic [N_CH*DATA_WD-1:0] s_data,
  input  logic [N_CH-1:0]         s_last,
  output logic [N_CH-1:0]         s_ready,
  output logic                    m_valid,
  output logic [DATA_WD-1:0]      m_data,
  output logic                    m_last,
  output logic [CH_WD-1:0]        m_chan,
  input  logic                    m_ready
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state;
  logic [CH_WD-1:0]   ptr;
  logic [CH_WD-1:0]   lock_idx;
  logic               lock_ext;

  logic [CH_WD-1:0]   rr_gnt;
  logic               rr_hit;
  logic [CH_WD-1:0]   gnt;
  logic               gnt_ok;
  logic               use_ext;
  logic               can_acc;
  logic               xfer;
  logic [DATA_WD-1:0] sel_data;
  logic               sel_last;
  int                 idx;

  function automatic logic [CH_WD-1:0] next_ch(input logic [CH_WD-1:0] c);
    // Explicit wrap so non-power-of-2 channel counts work.
    if (int'(c) == N_CH - 1) return '0;
    return c + 1'b1;
  endfunction

  // Descending scan: the last hit written is the nearest channel at or after ptr.
  always_comb begin
    rr_gnt = '0;
    rr_hit = 1'b0;
    idx    = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (s_valid[idx]) begin
        rr_gnt = CH_WD'(idx);
        rr_hit = 1'b1;
      end
    end
  end

  always_comb begin
    use_ext = 1'b0;
    gnt     = rr_gnt;
    gnt_ok  = rr_hit;
    if (state == LOCKED) begin
      gnt    = lock_idx;
      gnt_ok = 1'b1;
    end
`ifdef AXIS_MUX_EXT_SEL_EN
    else if (ext_sel_en) begin
      use_ext = 1'b1;
      gnt     = ext_sel;
      gnt_ok  = (int'(ext_sel) < N_CH);
    end
`endif
  end

  assign can_acc = !m_valid || m_ready;

  always_comb begin
    s_ready = '0;
    if (!rst && gnt_ok && can_acc) s_ready[gnt] = 1'b1;
  end

  assign xfer     = |(s_valid & s_ready);
  assign sel_data = s_data[int'(gnt)*DATA_WD +: DATA_WD];
  assign sel_last = s_last[gnt];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      lock_idx <= '0;
      lock_ext <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      m_chan   <= '0;
    end else if (xfer) begin
      m_valid <= 1'b1;
      m_data  <= sel_data;
      m_last  <= sel_last;
      m_chan  <= gnt;
      if (state == IDLE) begin
        if (!sel_last) begin
          state    <= LOCKED;
          lock_idx <= gnt;
          lock_ext <= use_ext;
        end else if (!use_ext) begin
          ptr <= next_ch(gnt);
        end
      end else if (sel_last) begin
        state <= IDLE;
        if (!lock_ext) ptr <= next_ch(lock_idx);
      end
    end else if (can_acc) begin
      m_valid <= 1'b0;
    end
  end

endmodule
